// File: rtl/cc_event_pkg.sv
// Shared types and defaults for the cross-clock event responder.
package cc_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        ACK     = 2'd2
    } cc_evt_state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cc_event_resp_sync_bit.sv
// N-flop level synchroniser for a single asynchronous bit; resets to 0.
module sync_bit #(
    parameter int STAGES = cc_event_pkg::SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the flop chain; only the last flop is used.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cc_event_resp.sv
// Receiving side of a 4-phase req/ack event handshake. The async req level
// is synchronised, each event is offered to a local consumer as a
// valid/ready transfer, and ack is returned only after acceptance so that
// consumer backpressure stalls the sender.
// Optional accepted-event counter: define CC_EVENT_CNT_EN.
module cc_event_resp
    import cc_event_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             ack,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             proto_err
`ifdef CC_EVENT_CNT_EN
    ,
    output logic [CNT_W-1:0] evt_cnt
`endif
);

    // Reject configurations the synchroniser or counter cannot support.
    if (SYNC_STAGES < 2 || CNT_W < 1) begin : g_bad_param
        $error("cc_event_resp: SYNC_STAGES must be >= 2 and CNT_W >= 1");
    end

    logic          req_s;
    cc_evt_state_t state_q, state_d;
    logic          ack_q, ack_d;
    logic          evt_valid_q, evt_valid_d;
    logic          proto_err_q, proto_err_d;
    logic          accept;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (req),
        .q_o   (req_s)
    );

    assign accept = evt_valid_q && evt_ready;

    // Next state, sticky error, and registered outputs decoded from next state.
    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: begin
                if (req_s) state_d = DELIVER;
            end
            DELIVER: begin
                // Event is already committed; a dropped req is flagged, not cancelled.
                if (!req_s) proto_err_d = 1'b1;
                if (accept) state_d = ACK;
            end
            ACK: begin
                // A re-raised req is only seen after returning through IDLE.
                if (!req_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ack_d       = (state_d == ACK);
        evt_valid_d = (state_d == DELIVER);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            evt_valid_q <= evt_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ack       = ack_q;
    assign evt_valid = evt_valid_q;
    assign proto_err = proto_err_q;

`ifdef CC_EVENT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = accept ? cnt_q + CNT_W'(1) : cnt_q;

    // Accepted-event counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cc_event_resp.sv
// Directed bench for cc_event_resp (SYNC_STAGES=2, CNT_W=2).
// Counter checks are active when built with CC_EVENT_CNT_EN.
module tb_cc_event_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       ack;
    logic       evt_valid;
    logic       evt_ready;
    logic       proto_err;
`ifdef CC_EVENT_CNT_EN
    logic [1:0] evt_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       req;
        logic       rdy;
        logic       ack;
        logic       vld;
        logic       err;
        logic [1:0] cnt;
    } vec_t;

    vec_t vec_q[$];

    always #5 clk = ~clk;

    cc_event_resp #(
        .SYNC_STAGES (2),
        .CNT_W       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .proto_err (proto_err)
`ifdef CC_EVENT_CNT_EN
        ,
        .evt_cnt   (evt_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_ack, input logic e_vld,
                            input logic e_err, input logic [1:0] e_cnt);
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(e_vld));
        chk({tag, ".proto_err"}, 32'(proto_err), 32'(e_err));
`ifdef CC_EVENT_CNT_EN
        chk({tag, ".evt_cnt"}, 32'(evt_cnt), 32'(e_cnt));
`else
        if (e_cnt == 2'd3) begin end
`endif
    endtask

    function automatic void push(input logic r, input logic y, input logic a,
                                 input logic v, input logic e, input logic [1:0] c);
        vec_t t;
        t.req = r; t.rdy = y; t.ack = a; t.vld = v; t.err = e; t.cnt = c;
        vec_q.push_back(t);
    endfunction

    // One full round trip: ready held low for 'wait_cyc' cycles of evt_valid.
    // Each row lists inputs sampled at the next edge and outputs after it.
    function automatic void add_event(input int wait_cyc, input logic e, input logic [1:0] c0);
        push(1, 1, 0, 0, e, c0);                    // sync stage 1 (ready ignored)
        push(1, 1, 0, 0, e, c0);                    // req_s high
        push(1, (wait_cyc == 0), 0, 1, e, c0);      // evt_valid rises
        for (int i = 0; i < wait_cyc; i++)
            push(1, 0, 0, 1, e, c0);                // held under backpressure
        push(1, 1, 1, 0, e, c0 + 2'd1);             // accepted -> ack
        push(0, 1, 1, 0, e, c0 + 2'd1);
        push(0, 1, 1, 0, e, c0 + 2'd1);             // req_s still high here
        push(0, 1, 0, 0, e, c0 + 2'd1);             // req_s low -> ack falls
    endfunction

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vec_q.size(); i++) begin
            req       = vec_q[i].req;
            evt_ready = vec_q[i].rdy;
            @(posedge clk); #1;
            chk_outs($sformatf("%s[%0d]", tag, i), vec_q[i].ack, vec_q[i].vld,
                     vec_q[i].err, vec_q[i].cnt);
        end
        vec_q.delete();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; evt_ready = 1'b0;
        #12;
        chk_outs("reset", 0, 0, 0, 2'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1: ready=1 round trip; 2: 10 cycles backpressure; 3: two more round trips (wraps CNT_W=2)
        add_event(0, 0, 2'd0);
        add_event(10, 0, 2'd1);
        add_event(0, 0, 2'd2);
        add_event(0, 0, 2'd3);
        // 4: req high one cycle only -> committed delivery, 1-cycle ack, sticky proto_err
        push(1, 0, 0, 0, 0, 2'd0);
        push(0, 0, 0, 0, 0, 2'd0);
        push(0, 1, 0, 1, 0, 2'd0);
        push(0, 1, 1, 0, 1, 2'd1);
        push(0, 1, 0, 0, 1, 2'd1);
        push(0, 1, 0, 0, 1, 2'd1);
        push(0, 0, 0, 0, 1, 2'd1);
        run_vectors("seq");

        // 5: async reset while in DELIVER, req kept high -> new event after release
        req = 1'b1; evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("rst_pre", 0, 1, 1, 2'd1);
        #2 rst = 1'b1;
        #1;
        chk_outs("rst_async", 0, 0, 0, 2'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; chk_outs("rst_e1", 0, 0, 0, 2'd0);
        @(posedge clk); #1; chk_outs("rst_e2", 0, 0, 0, 2'd0);
        @(posedge clk); #1; chk_outs("rst_e3", 0, 1, 0, 2'd0);
        evt_ready = 1'b1;
        @(posedge clk); #1; chk_outs("rst_acc", 1, 0, 0, 2'd1);
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1; chk_outs("rst_done", 0, 0, 0, 2'd1);

        // 6: four more events, five since reset -> count wraps to 1
        add_event(0, 0, 2'd1);
        add_event(2, 0, 2'd2);
        add_event(0, 0, 2'd3);
        add_event(1, 0, 2'd0);
        run_vectors("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
